// File: rtl/mi_nios_touch_pen_conditioner.sv
// mi_nios_touch_pen_conditioner: synchronises and debounces PENIRQ, latches press/release edges, raises a maskable IRQ
module mi_nios_touch_pen_conditioner #(
  parameter int CNT_W = 16,
  parameter int DEBOUNCE_DEFAULT = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        pen_irq_n,
  output logic        out_port,
  output logic        irq
);
  typedef enum logic [1:0] {UP, CHK_DN, DN, CHK_UP} state_t;
  state_t state, state_nx;
  logic sync1, sync2, raw, wr;
  logic [CNT_W-1:0] counter, counter_nx, counter_inc, debounce, deb_eff;
  logic [1:0] irq_mask, edge_capture, edge_set, edge_clr;
  logic [31:0] rd_mux;
  logic unused_wd;
  assign unused_wd = ^writedata[31:CNT_W];
  assign raw = ~sync2;
  assign wr = chipselect & ~write_n;
  assign deb_eff = debounce == '0 ? CNT_W'(1) : debounce;
  assign counter_inc = counter + CNT_W'(~&counter);
  assign out_port = state == DN || state == CHK_UP;
  assign irq = |(edge_capture & irq_mask);
  assign edge_clr = wr && address == 2'd3 ? writedata[1:0] : 2'b00;
  assign rd_mux = address == 2'd0 ? {30'd0, raw, out_port} :
                  address == 2'd1 ? {30'd0, irq_mask} :
                  address == 2'd2 ? 32'(debounce) : {30'd0, edge_capture};
  always_comb begin
    state_nx = state;
    counter_nx = counter;
    edge_set = 2'b00;
    case (state)
      UP: if (raw) begin
        state_nx = CHK_DN;
        counter_nx = CNT_W'(1);
      end
      CHK_DN: if (!raw) begin
        state_nx = UP;
        counter_nx = '0;
      end else if (counter >= deb_eff) begin
        state_nx = DN;
        counter_nx = '0;
        edge_set = 2'b01;
      end else counter_nx = counter_inc;
      DN: if (!raw) begin
        state_nx = CHK_UP;
        counter_nx = CNT_W'(1);
      end
      CHK_UP: if (raw) begin
        state_nx = DN;
        counter_nx = '0;
      end else if (counter >= deb_eff) begin
        state_nx = UP;
        counter_nx = '0;
        edge_set = 2'b10;
      end else counter_nx = counter_inc;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      state <= UP;
      counter <= '0;
      debounce <= CNT_W'(DEBOUNCE_DEFAULT);
      irq_mask <= 2'b00;
      edge_capture <= 2'b00;
      readdata <= '0;
    end else begin
      sync1 <= pen_irq_n;
      sync2 <= sync1;
      state <= state_nx;
      counter <= counter_nx;
      readdata <= rd_mux;
      if (wr && address == 2'd1) irq_mask <= writedata[1:0];
      if (wr && address == 2'd2) debounce <= writedata[CNT_W-1:0];
      edge_capture <= (edge_capture & ~edge_clr) | edge_set;
    end
  end
endmodule

// File: tb/tb_mi_nios_touch_pen_conditioner.sv
// tb_mi_nios_touch_pen_conditioner: scoreboard bench with a run-length reference model of the pen conditioner
module tb_mi_nios_touch_pen_conditioner;
  logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1, pen_irq_n = 1;
  logic [1:0] address = 0;
  logic [31:0] writedata = 0, readdata;
  logic out_port, irq;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mi_nios_touch_pen_conditioner dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .pen_irq_n(pen_irq_n), .out_port(out_port), .irq(irq)
  );
  bit m_p1 = 1, m_p2 = 1, m_level = 0;
  int m_run = 0, m_deb = 50000;
  bit [1:0] m_ec = 0, m_mask = 0;
  logic [31:0] q_rd[$];
  logic [1:0] q_lvl[$];
  bit rd_vld = 0;
  always @(posedge clk) rd_vld <= chipselect && write_n && reset_n;
  // model: level flips once raw has disagreed with it for max(deb,1)+1 consecutive samples
  task automatic tick();
    bit raw;
    bit [1:0] set, clr;
    logic [31:0] e;
    int eff;
    raw = ~m_p2;
    if (chipselect && write_n && reset_n) begin
      case (address)
        2'd0: e = {30'd0, raw, m_level};
        2'd1: e = {30'd0, m_mask};
        2'd2: e = 32'(m_deb);
        default: e = {30'd0, m_ec};
      endcase
      q_rd.push_back(e);
    end
    if (!reset_n) begin
      m_p1 = 1; m_p2 = 1; m_level = 0; m_run = 0; m_deb = 50000; m_ec = 0; m_mask = 0;
    end else begin
      set = 0; clr = 0;
      eff = m_deb == 0 ? 1 : m_deb;
      if (raw != m_level) begin
        m_run++;
        if (m_run >= eff + 1) begin
          m_level = raw;
          m_run = 0;
          set = raw ? 2'b01 : 2'b10;
        end
      end else m_run = 0;
      if (chipselect && !write_n)
        case (address)
          2'd1: m_mask = writedata[1:0];
          2'd2: m_deb = int'(writedata[15:0]);
          2'd3: clr = writedata[1:0];
          default: ;
        endcase
      m_ec = (m_ec & ~clr) | set;
      m_p2 = m_p1;
      m_p1 = pen_irq_n;
    end
    @(posedge clk);
    q_lvl.push_back({m_level, |(m_ec & m_mask)});
    @(negedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    logic [1:0] el;
    logic [31:0] er;
    if (q_lvl.size() > 0) begin
      el = q_lvl.pop_front();
      total++;
      if ({out_port, irq} !== el) begin
        bad++;
        $display("FAIL out_irq got=%b exp=%b t=%0t", {out_port, irq}, el, $time);
      end
    end
    if (rd_vld) begin
      total++;
      if (q_rd.size() == 0) begin
        bad++;
        $display("FAIL readdata no expectation queued t=%0t", $time);
      end else begin
        er = q_rd.pop_front();
        if (readdata !== er) begin
          bad++;
          $display("FAIL readdata got=%0d exp=%0d t=%0t", readdata, er, $time);
        end
      end
    end
  end
  task automatic chk(input string n, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    tick();
    chipselect = 0; write_n = 1;
  endtask
  task automatic rd(input logic [1:0] a);
    address = a; chipselect = 1; write_n = 1;
    tick();
    chipselect = 0;
  endtask
  task automatic wait_out(input bit v, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (out_port !== v && n < 200);
  endtask
  initial begin
    int n;
    repeat (3) tick();
    reset_n = 1;
    tick();
    chk("rst_out", out_port, 0);
    chk("rst_irq", irq, 0);
    rd(0); chk("rst_a0", readdata, 0);
    rd(1); chk("rst_a1", readdata, 0);
    rd(2); chk("rst_a2", readdata, 50000);
    rd(3); chk("rst_a3", readdata, 0);
    wr(2, 8);
    wr(1, 3);
    pen_irq_n = 0;
    repeat (5) tick();
    pen_irq_n = 1;
    repeat (12) tick();
    chk("glitch_out", out_port, 0);
    chk("glitch_irq", irq, 0);
    rd(3); chk("glitch_ec", readdata, 0);
    pen_irq_n = 0;
    wait_out(1, n);
    chk("press_lat", n, 11);
    repeat (8) tick();
    rd(3); chk("press_ec", readdata, 1);
    chk("press_irq", irq, 1);
    pen_irq_n = 1;
    wait_out(0, n);
    chk("release_lat", n, 11);
    rd(3); chk("release_ec", readdata, 3);
    wr(3, 1);
    rd(3); chk("w1c_bit0", readdata, 2);
    chk("w1c_irq_held", irq, 1);
    wr(3, 2);
    chk("w1c_irq_clr", irq, 0);
    pen_irq_n = 0;
    repeat (10) tick();
    wr(3, 1);
    rd(3); chk("set_beats_clr", readdata, 1);
    wr(1, 0);
    chk("mask_off_irq", irq, 0);
    rd(3); chk("mask_off_ec", readdata, 1);
    wr(2, 0);
    wr(1, 3);
    pen_irq_n = 1;
    wait_out(0, n); chk("deb0_rel", n, 4);
    pen_irq_n = 0;
    wait_out(1, n); chk("deb0_press", n, 4);
    pen_irq_n = 1;
    wait_out(0, n); chk("deb0_rel2", n, 4);
    wr(2, 8);
    pen_irq_n = 0;
    repeat (5) tick();
    reset_n = 0;
    tick();
    chk("midrst_out", out_port, 0);
    chk("midrst_irq", irq, 0);
    reset_n = 1;
    rd(0); chk("midrst_a0", readdata, 0);
    rd(1); chk("midrst_a1", readdata, 0);
    rd(2); chk("midrst_a2", readdata, 50000);
    rd(3); chk("midrst_a3", readdata, 0);
    wr(2, 3);
    repeat (10) tick();
    chk("held_after_rst", out_port, 1);
    rd(3); chk("held_ec", readdata, 1);
    wr(1, 3);
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) wr(2, $urandom_range(0, 6));
      else if (r == 2) wr(3, $urandom);
      else if (r == 3) wr(1, $urandom);
      else if (r == 4) wr(0, $urandom);
      else if (r < 7) rd(2'($urandom_range(0, 3)));
      else begin
        pen_irq_n = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 10)) tick();
      end
    end
    repeat (3) tick();
    chk("drain_rd", q_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
